// File: rtl/ddr_link_pkg.sv
// Shared definitions for the LVDS DDR link: default word geometry, the frame
// word used for alignment, and the alignment FSM state type.
package ddr_link_pkg;

  localparam int WORD_BITS_DEF = 8;
  localparam logic [WORD_BITS_DEF-1:0] FRAME_PATTERN_DEF = 8'hF0;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } linkState_t;

endpackage

// File: rtl/ddr_in_capture.sv
// Single-lane DDR input capture. The rise bit is taken on posedge, the fall
// bit on the following negedge, and both are re-registered together on the
// next posedge so the rest of the receiver lives purely in the posedge domain.
module ddr_in_capture (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       i_d,
  output logic [1:0] o_pair
);

  logic       r_rise;
  logic       r_fall;
  logic       r_rstSeen;
  logic [1:0] r_pair;

  // Rise-edge sample and the re-registered {rise, fall} pair; rise is earlier in time.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_pair <= 2'b00;
    end else begin
      r_rise <= i_d;
      r_pair <= {r_rise, r_fall};
    end
  end

  // Carries the posedge-sampled reset over to the negedge register.
  always_ff @(posedge clk_in) begin
    r_rstSeen <= rst;
  end

  // Fall-edge sample, cleared by the reset seen at the preceding posedge.
  always_ff @(negedge clk_in) begin
    if (r_rstSeen) begin
      r_fall <= 1'b0;
    end else begin
      r_fall <= i_d;
    end
  end

  assign o_pair = r_pair;

endmodule

// File: rtl/ddr_adc_rx.sv
// Receive side of the ADC LVDS DDR link. Captures N_LANES data lanes plus the
// frame lane, deserialises them into WORD_BITS-bit words, bitslips until the
// frame lane shows FRAME_PATTERN, and hands aligned samples out over
// valid/ready. A word that cannot be delivered because the consumer is stalled
// is dropped and flagged in the sticky overflow bit.
module ddr_adc_rx
  import ddr_link_pkg::*;
#(
  parameter int                   N_LANES       = 2,
  parameter int                   WORD_BITS     = WORD_BITS_DEF,
  parameter logic [WORD_BITS-1:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
  parameter int                   LOCK_COUNT    = 4,
  parameter int                   MISS_LIMIT    = 2,
  parameter int                   SLIP_SETTLE   = 2
) (
  input  logic                           clk_in,
  input  logic                           rst,
  input  logic [N_LANES-1:0]             din,
  input  logic                           frame_in,
  output logic [N_LANES*WORD_BITS-1:0]   out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           locked,
  output logic                           lost_lock,
  output logic                           overflow,
  output logic [$clog2(WORD_BITS)-1:0]   bit_offset
);

  localparam int OFF_W    = $clog2(WORD_BITS);
  localparam int HIST_W   = 2 * WORD_BITS;
  localparam int BEAT_W   = $clog2(WORD_BITS / 2);
  localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W   = $clog2(MISS_LIMIT + 1);
  localparam int SETTLE_W = (SLIP_SETTLE < 1) ? 1 : $clog2(SLIP_SETTLE + 1);

  logic [1:0]                 w_lanePair [N_LANES];
  logic [1:0]                 w_framePair;
  logic [HIST_W-1:0]          r_hist [N_LANES];
  logic [HIST_W-1:0]          r_histFrame;
  logic [BEAT_W-1:0]          r_beatCnt;
  logic                       w_boundary;
  logic [WORD_BITS-1:0]       w_frameWord;
  logic                       w_frameMatch;
  logic [N_LANES*WORD_BITS-1:0] w_laneWords;

  linkState_t                 r_state;
  linkState_t                 w_stateNext;
  logic [OFF_W-1:0]           r_offset;
  logic [OFF_W-1:0]           w_offsetNext;
  logic [MATCH_W-1:0]         r_matchCnt;
  logic [MATCH_W-1:0]         w_matchNext;
  logic [MISS_W-1:0]          r_missCnt;
  logic [MISS_W-1:0]          w_missNext;
  logic [SETTLE_W-1:0]        r_settleCnt;
  logic [SETTLE_W-1:0]        w_settleNext;
  logic                       w_emit;
  logic                       w_lostLock;

  logic [N_LANES*WORD_BITS-1:0] r_outData;
  logic                       r_outValid;
  logic                       r_overflow;
  logic                       r_lostLock;

  for (genvar g = 0; g < N_LANES; g++) begin : g_laneCap
    ddr_in_capture u_cap (
      .clk_in (clk_in),
      .rst    (rst),
      .i_d    (din[g]),
      .o_pair (w_lanePair[g])
    );
  end

  ddr_in_capture u_frameCap (
    .clk_in (clk_in),
    .rst    (rst),
    .i_d    (frame_in),
    .o_pair (w_framePair)
  );

  // Two-bit-per-cycle history shift registers, oldest bit towards the MSB.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        r_hist[i] <= '0;
      end
      r_histFrame <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        r_hist[i] <= {r_hist[i][HIST_W-3:0], w_lanePair[i]};
      end
      r_histFrame <= {r_histFrame[HIST_W-3:0], w_framePair};
    end
  end

  // Free-running beat counter; its wrap marks one word's worth of new bits.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_beatCnt <= '0;
    end else if (w_boundary) begin
      r_beatCnt <= '0;
    end else begin
      r_beatCnt <= r_beatCnt + 1'b1;
    end
  end

  assign w_boundary   = (r_beatCnt == BEAT_W'(WORD_BITS / 2 - 1));
  assign w_frameWord  = r_histFrame[r_offset +: WORD_BITS];
  assign w_frameMatch = (w_frameWord == FRAME_PATTERN);

  // Slice every data lane at the current slip offset and pack lane i into its field.
  always_comb begin
    w_laneWords = '0;
    for (int i = 0; i < N_LANES; i++) begin
      w_laneWords[i*WORD_BITS +: WORD_BITS] = r_hist[i][r_offset +: WORD_BITS];
    end
  end

  // Alignment state, slip offset and the match/miss/settle counters.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_offset    <= '0;
      r_matchCnt  <= '0;
      r_missCnt   <= '0;
      r_settleCnt <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_offset    <= w_offsetNext;
      r_matchCnt  <= w_matchNext;
      r_missCnt   <= w_missNext;
      r_settleCnt <= w_settleNext;
    end
  end

  // Boundary decision: slip/count while searching, tolerate isolated misses once locked.
  always_comb begin
    w_stateNext  = r_state;
    w_offsetNext = r_offset;
    w_matchNext  = r_matchCnt;
    w_missNext   = r_missCnt;
    w_settleNext = r_settleCnt;
    w_emit       = 1'b0;
    w_lostLock   = 1'b0;
    if (w_boundary) begin
      case (r_state)
        SEARCH: begin
          if (r_settleCnt != '0) begin
            w_settleNext = r_settleCnt - 1'b1;
          end else if (w_frameMatch) begin
            if (r_matchCnt == MATCH_W'(LOCK_COUNT - 1)) begin
              w_stateNext = LOCKED;
              w_matchNext = '0;
            end else begin
              w_matchNext = r_matchCnt + 1'b1;
            end
          end else begin
            w_offsetNext = (r_offset == OFF_W'(WORD_BITS - 1)) ? '0 : r_offset + 1'b1;
            w_matchNext  = '0;
            w_settleNext = SETTLE_W'(SLIP_SETTLE);
          end
        end
        LOCKED: begin
          if (w_frameMatch) begin
            w_missNext = '0;
            w_emit     = 1'b1;
          end else if (r_missCnt == MISS_W'(MISS_LIMIT - 1)) begin
            w_stateNext = SEARCH;
            w_missNext  = '0;
            w_matchNext = '0;
            w_lostLock  = 1'b1;
          end else begin
            w_missNext = r_missCnt + 1'b1;
            w_emit     = 1'b1;
          end
        end
        default: begin
          w_stateNext = SEARCH;
        end
      endcase
    end
  end

  // Output holding register: load when free or being drained, otherwise drop and flag.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_overflow <= 1'b0;
      r_lostLock <= 1'b0;
    end else begin
      r_lostLock <= w_lostLock;
      if (w_emit && (!r_outValid || out_ready)) begin
        r_outData  <= w_laneWords;
        r_outValid <= 1'b1;
      end else if (w_emit) begin
        r_overflow <= 1'b1;
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_data   = r_outData;
  assign out_valid  = r_outValid;
  assign overflow   = r_overflow;
  assign lost_lock  = r_lostLock;
  assign locked     = (r_state == LOCKED);
  assign bit_offset = r_offset;

endmodule
